// File: rtl/ct_lsu_dcache_ld_tag_arb_if.sv
// ct_lsu_dcache_ld_tag_arb_if: requester, response and tag-array signals of the load-side tag arbiter
interface ct_lsu_dcache_ld_tag_arb_if #(
    parameter int IDX_W = 9,
    parameter int TAG_W = 54
);
    logic             rf_req;
    logic [IDX_W-1:0] rf_idx;
    logic [1:0]       rf_way_wen;
    logic [TAG_W-1:0] rf_din;
    logic             rf_gnt;
    logic             sn_req;
    logic [IDX_W-1:0] sn_idx;
    logic             sn_gnt;
    logic             ld_req;
    logic [IDX_W-1:0] ld_idx;
    logic             ld_gnt;
    logic             sn_rsp_vld;
    logic             ld_rsp_vld;
    logic [TAG_W-1:0] rsp_data;
    logic             init_done;
    logic             tag_gateclk_en;
    logic             tag_sel_b;
    logic             tag_gwen_b;
    logic [1:0]       tag_wen_b;
    logic [IDX_W-1:0] tag_idx;
    logic [TAG_W-1:0] tag_din;
    logic [TAG_W-1:0] tag_dout;
    modport master (
        output rf_req, rf_idx, rf_way_wen, rf_din, sn_req, sn_idx, ld_req, ld_idx, tag_dout,
        input  rf_gnt, sn_gnt, ld_gnt, sn_rsp_vld, ld_rsp_vld, rsp_data, init_done,
               tag_gateclk_en, tag_sel_b, tag_gwen_b, tag_wen_b, tag_idx, tag_din
    );
    modport slave (
        input  rf_req, rf_idx, rf_way_wen, rf_din, sn_req, sn_idx, ld_req, ld_idx, tag_dout,
        output rf_gnt, sn_gnt, ld_gnt, sn_rsp_vld, ld_rsp_vld, rsp_data, init_done,
               tag_gateclk_en, tag_sel_b, tag_gwen_b, tag_wen_b, tag_idx, tag_din
    );
endinterface

// File: rtl/ct_lsu_dcache_ld_tag_arb.sv
// ct_lsu_dcache_ld_tag_arb: init sweep plus LD(starved) > RF > SN > LD arbitration of the load-side tag SRAM
module ct_lsu_dcache_ld_tag_arb #(
    parameter int IDX_W   = 9,
    parameter int TAG_W   = 54,
    parameter int AGE_MAX = 7
) (
    input logic forever_cpuclk,
    input logic cpurst_b,
    ct_lsu_dcache_ld_tag_arb_if.slave bus
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_cnt;
    logic [2:0]       ld_age;
    logic             sn_vld;
    logic             ld_vld;
    logic             in_init;
    logic             in_run;
    logic             starved;
    logic             rf_wr;
    logic             rd;

    always_comb begin
        in_init = cpurst_b && state == INIT;
        in_run  = cpurst_b && state == RUN;
        starved = bus.ld_req && ld_age == 3'(AGE_MAX);
        bus.ld_gnt = in_run && bus.ld_req && (starved || (!bus.rf_req && !bus.sn_req));
        bus.rf_gnt = in_run && bus.rf_req && !starved;
        bus.sn_gnt = in_run && bus.sn_req && !bus.rf_req && !starved;
        // an RF grant with no way enabled is accepted but never touches the array
        rf_wr = bus.rf_gnt && |bus.rf_way_wen;
        rd    = bus.sn_gnt || bus.ld_gnt;
        bus.tag_sel_b      = !(in_init || rf_wr || rd);
        bus.tag_gwen_b     = !(in_init || rf_wr);
        bus.tag_gateclk_en = !bus.tag_sel_b;
        bus.tag_wen_b      = in_init ? 2'b00 : rf_wr ? ~bus.rf_way_wen : 2'b11;
        bus.tag_idx        = in_init ? init_cnt : bus.rf_gnt ? bus.rf_idx :
                             bus.sn_gnt ? bus.sn_idx : bus.ld_gnt ? bus.ld_idx : '0;
        bus.tag_din        = bus.rf_gnt ? bus.rf_din : '0;
        bus.init_done      = in_run;
        bus.rsp_data       = bus.tag_dout;
        bus.sn_rsp_vld     = sn_vld;
        bus.ld_rsp_vld     = ld_vld;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state    <= INIT;
            init_cnt <= '0;
            ld_age   <= '0;
            sn_vld   <= 1'b0;
            ld_vld   <= 1'b0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt) state <= RUN;
            end
            sn_vld <= bus.sn_gnt;
            ld_vld <= bus.ld_gnt;
            ld_age <= (bus.ld_req && !bus.ld_gnt) ?
                      (ld_age == 3'(AGE_MAX) ? ld_age : ld_age + 3'd1) : 3'd0;
        end
    end
endmodule

// File: tb/tb_ct_lsu_dcache_ld_tag_arb.sv
// tb_ct_lsu_dcache_ld_tag_arb: directed and random stimulus against a cycle-level behavioural model
module tb_ct_lsu_dcache_ld_tag_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   m_init;
    int   m_cnt;
    int   m_age;
    bit   m_snv;
    bit   m_ldv;
    bit   e_rf;
    bit   e_sn;
    bit   e_ld;

    ct_lsu_dcache_ld_tag_arb_if bus ();

    ct_lsu_dcache_ld_tag_arb dut (
        .forever_cpuclk(clk),
        .cpurst_b(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit rf, input bit sn, input bit ld, input int ri, input int si,
                           input int li, input logic [1:0] w, input logic [53:0] d);
        bus.rf_req = rf;
        bus.sn_req = sn;
        bus.ld_req = ld;
        bus.rf_idx = 9'(ri);
        bus.sn_idx = 9'(si);
        bus.ld_idx = 9'(li);
        bus.rf_way_wen = w;
        bus.rf_din = d;
    endtask

    task automatic check_model();
        bit xr, xs, xl, xsel, xgw, xdone;
        logic [1:0] xw;
        logic [8:0] xi;
        logic [53:0] xd;
        xr = 0; xs = 0; xl = 0; xsel = 1; xgw = 1; xw = 2'b11; xi = '0; xd = '0; xdone = 0;
        if (rst_n && m_init) begin
            xsel = 0; xgw = 0; xw = 2'b00; xi = 9'(m_cnt);
        end else if (rst_n) begin
            xdone = 1;
            if (bus.ld_req && m_age == 7) xl = 1;
            else if (bus.rf_req) xr = 1;
            else if (bus.sn_req) xs = 1;
            else if (bus.ld_req) xl = 1;
            if (xr) begin
                xi = bus.rf_idx;
                xd = bus.rf_din;
                if (bus.rf_way_wen != 2'b00) begin
                    xsel = 0; xgw = 0; xw = ~bus.rf_way_wen;
                end
            end
            if (xs || xl) begin
                xsel = 0;
                xi = xs ? bus.sn_idx : bus.ld_idx;
            end
        end
        e_rf = xr; e_sn = xs; e_ld = xl;
        chk("rf_gnt", 64'(bus.rf_gnt), 64'(xr));
        chk("sn_gnt", 64'(bus.sn_gnt), 64'(xs));
        chk("ld_gnt", 64'(bus.ld_gnt), 64'(xl));
        chk("init_done", 64'(bus.init_done), 64'(xdone));
        chk("sel_b", 64'(bus.tag_sel_b), 64'(xsel));
        chk("gwen_b", 64'(bus.tag_gwen_b), 64'(xgw));
        chk("wen_b", 64'(bus.tag_wen_b), 64'(xw));
        chk("gateclk_en", 64'(bus.tag_gateclk_en), 64'(!xsel));
        chk("tag_idx", 64'(bus.tag_idx), 64'(xi));
        chk("tag_din", 64'(bus.tag_din), 64'(xd));
        chk("sn_rsp_vld", 64'(bus.sn_rsp_vld), 64'(m_snv));
        chk("ld_rsp_vld", 64'(bus.ld_rsp_vld), 64'(m_ldv));
        chk("rsp_data", 64'(bus.rsp_data), 64'(bus.tag_dout));
    endtask

    // inputs are set just after a negedge; compare, clock the model, return at the next negedge
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        if (!rst_n) begin
            m_init = 1; m_cnt = 0; m_age = 0; m_snv = 0; m_ldv = 0;
        end else begin
            m_snv = e_sn;
            m_ldv = e_ld;
            if (m_init) begin
                if (m_cnt == 511) m_init = 0;
                m_cnt = (m_cnt + 1) % 512;
            end
            m_age = (bus.ld_req && !e_ld) ? ((m_age < 7) ? m_age + 1 : 7) : 0;
        end
        @(negedge clk);
    endtask

    task automatic rand_req();
        set_req($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                2'($urandom_range(0, 3)), {22'($urandom), 32'($urandom)});
        bus.tag_dout = {22'($urandom), 32'($urandom)};
    endtask

    initial begin
        m_init = 1; m_cnt = 0; m_age = 0; m_snv = 0; m_ldv = 0;
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 2'b00, '0);
        bus.tag_dout = '0;
        @(negedge clk);
        cycle();
        rand_req();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_req();
            cycle();
        end
        rst_n = 1'b0;
        rand_req();
        #1;
        chk("sel_b_in_reset", 64'(bus.tag_sel_b), 64'd1);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            rand_req();
            #1;
            chk("sweep_idx", 64'(bus.tag_idx), 64'(i));
            chk("sweep_no_gnt", 64'({bus.rf_gnt, bus.sn_gnt, bus.ld_gnt}), 64'd0);
            cycle();
        end
        set_req(0, 0, 0, 0, 0, 0, 2'b00, '0);
        #1;
        chk("init_done_rise", 64'(bus.init_done), 64'd1);
        cycle();
        set_req(1, 1, 1, 5, 6, 7, 2'b11, 54'h15_5555_AAAA_0F0F);
        #1;
        chk("prio_rf", 64'({bus.rf_gnt, bus.tag_gwen_b}), 64'b10);
        chk("prio_rf_idx", 64'(bus.tag_idx), 64'd5);
        cycle();
        bus.rf_req = 0;
        #1;
        chk("prio_sn", 64'(bus.sn_gnt), 64'd1);
        chk("prio_sn_idx", 64'(bus.tag_idx), 64'd6);
        cycle();
        bus.sn_req = 0;
        #1;
        chk("sn_rsp_next", 64'(bus.sn_rsp_vld), 64'd1);
        chk("prio_ld", 64'(bus.ld_gnt), 64'd1);
        chk("prio_ld_idx", 64'(bus.tag_idx), 64'd7);
        cycle();
        set_req(0, 0, 0, 0, 0, 0, 2'b00, '0);
        cycle();
        set_req(1, 0, 1, 33, 0, 44, 2'b01, 54'h1234);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("starve_rf", 64'(bus.rf_gnt), 64'(i != 7));
            chk("starve_ld", 64'(bus.ld_gnt), 64'(i == 7));
            cycle();
        end
        set_req(0, 0, 1, 0, 0, 9, 2'b00, '0);
        cycle();
        bus.ld_req = 0;
        bus.tag_dout = 54'h3_FFFF_0000_1234;
        #1;
        chk("ld_rsp_vld", 64'(bus.ld_rsp_vld), 64'd1);
        chk("ld_rsp_data", 64'(bus.rsp_data), 64'h3_FFFF_0000_1234);
        chk("ld_rsp_no_sn", 64'(bus.sn_rsp_vld), 64'd0);
        cycle();
        set_req(1, 0, 0, 100, 0, 0, 2'b10, 54'h2A_AAAA_5555_AAAA);
        #1;
        chk("partial_wen_b", 64'(bus.tag_wen_b), 64'b01);
        chk("partial_din", 64'(bus.tag_din), 64'h2A_AAAA_5555_AAAA);
        cycle();
        bus.rf_way_wen = 2'b00;
        #1;
        chk("noop_rf", 64'({bus.rf_gnt, bus.tag_sel_b, bus.tag_gateclk_en}), 64'b110);
        cycle();
        for (int i = 0; i < 400; i++) begin
            rand_req();
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
